// File: rtl/pc_seq_pkg.sv
// Shared types and alignment helpers for the program-counter sequencer.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      PCS_BOOT = 2'd0,
      PCS_RUN  = 2'd1,
      PCS_HALT = 2'd2
   } pcs_state_t;

   localparam int unsigned PCS_INSTR_BYTES = 4;
   localparam int unsigned PCS_ALIGN_W     = $clog2(PCS_INSTR_BYTES);

   // Number of low address bits that must be zero for a legal fetch target.
   function automatic int unsigned align_w(input int unsigned instr_bytes);
      return (instr_bytes <= 1) ? 0 : $clog2(instr_bytes);
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control and fetch-address bundle between next-address logic and the PC sequencer.
interface pc_sequencer_if #(
   parameter int XLEN = 32
);
   logic            stall_i;
   logic            redirect_valid_i;
   logic [XLEN-1:0] redirect_target_i;
   logic            trap_i;
   logic            trap_return_i;
   logic            halt_i;
   logic            resume_i;
   logic [XLEN-1:0] pc_o;
   logic            pc_valid_o;
   logic [XLEN-1:0] pc_plus_o;
   logic [XLEN-1:0] epc_o;
   logic            misalign_o;
   logic [1:0]      state_o;

   modport master (
      output stall_i, redirect_valid_i, redirect_target_i,
             trap_i, trap_return_i, halt_i, resume_i,
      input  pc_o, pc_valid_o, pc_plus_o, epc_o, misalign_o, state_o
   );

   modport slave (
      input  stall_i, redirect_valid_i, redirect_target_i,
             trap_i, trap_return_i, halt_i, resume_i,
      output pc_o, pc_valid_o, pc_plus_o, epc_o, misalign_o, state_o
   );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational priority selection of the next PC, next state and EPC capture.
module pc_next_sel
   import pc_seq_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter int              INSTR_BYTES = PCS_INSTR_BYTES,
   parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100
) (
   input  pcs_state_t      i_state,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_pc_plus,
   input  logic [XLEN-1:0] i_epc,
   input  logic            i_stall,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_target,
   input  logic            i_trap,
   input  logic            i_trap_return,
   input  logic            i_halt,
   input  logic            i_resume,
   output logic [XLEN-1:0] o_next_pc,
   output pcs_state_t      o_next_state,
   output logic            o_epc_we,
   output logic            o_misalign
);
   localparam int unsigned ALIGN_W = align_w(INSTR_BYTES);

   logic w_target_misaligned;

   generate
      if (ALIGN_W == 0) begin : g_no_align
         assign w_target_misaligned = 1'b0;
      end else begin : g_align
         assign w_target_misaligned = |i_redirect_target[ALIGN_W-1:0];
      end
   endgenerate

   always_comb begin
      o_next_pc    = i_pc;
      o_next_state = i_state;
      o_epc_we     = 1'b0;
      o_misalign   = 1'b0;
      case (i_state)
         PCS_BOOT: o_next_state = PCS_RUN;
         PCS_RUN: begin
            // Flushes outrank stall, so stall is only consulted last.
            if (i_trap) begin
               o_epc_we  = 1'b1;
               o_next_pc = TRAP_VECTOR;
            end else if (i_trap_return) begin
               o_next_pc = i_epc;
            end else if (i_redirect_valid && !w_target_misaligned) begin
               o_next_pc = i_redirect_target;
            end else if (i_redirect_valid) begin
               o_epc_we   = 1'b1;
               o_next_pc  = TRAP_VECTOR;
               o_misalign = 1'b1;
            end else if (i_halt) begin
               o_next_state = PCS_HALT;
            end else if (!i_stall) begin
               o_next_pc = i_pc_plus;
            end
         end
         PCS_HALT: begin
            if (i_trap) begin
               o_epc_we     = 1'b1;
               o_next_pc    = TRAP_VECTOR;
               o_next_state = PCS_RUN;
            end else if (i_resume) begin
               o_next_state = PCS_RUN;
            end
         end
         default: o_next_state = PCS_BOOT;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch-address register, EPC and BOOT/RUN/HALT FSM.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter int              INSTR_BYTES  = PCS_INSTR_BYTES,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input logic           clk,
   input logic           rst_n,
   pc_sequencer_if.slave bus
);
   pcs_state_t      r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_epc;
   logic            r_misalign;

   pcs_state_t      w_next_state;
   logic [XLEN-1:0] w_next_pc;
   logic [XLEN-1:0] w_pc_plus;
   logic            w_epc_we;
   logic            w_misalign;

   assign w_pc_plus = r_pc + XLEN'(INSTR_BYTES);

   pc_next_sel #(
      .XLEN        (XLEN),
      .INSTR_BYTES (INSTR_BYTES),
      .TRAP_VECTOR (TRAP_VECTOR)
   ) u_next_sel (
      .i_state           (r_state),
      .i_pc              (r_pc),
      .i_pc_plus         (w_pc_plus),
      .i_epc             (r_epc),
      .i_stall           (bus.stall_i),
      .i_redirect_valid  (bus.redirect_valid_i),
      .i_redirect_target (bus.redirect_target_i),
      .i_trap            (bus.trap_i),
      .i_trap_return     (bus.trap_return_i),
      .i_halt            (bus.halt_i),
      .i_resume          (bus.resume_i),
      .o_next_pc         (w_next_pc),
      .o_next_state      (w_next_state),
      .o_epc_we          (w_epc_we),
      .o_misalign        (w_misalign)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= PCS_BOOT;
         r_pc       <= RESET_VECTOR;
         r_epc      <= '0;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_pc       <= w_next_pc;
         r_misalign <= w_misalign;
         if (w_epc_we) begin
            r_epc <= r_pc;
         end
      end
   end

   assign bus.pc_o       = r_pc;
   assign bus.pc_plus_o  = w_pc_plus;
   assign bus.epc_o      = r_epc;
   assign bus.misalign_o = r_misalign;
   assign bus.state_o    = r_state;
   // A stalled RUN cycle is not a live fetch even though the address is held.
   assign bus.pc_valid_o = (r_state == PCS_RUN) && !bus.stall_i;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table-driven scenarios with a scoreboard queue.
module tb_pc_sequencer;

   localparam logic L0 = 1'b0;
   localparam logic L1 = 1'b1;

   typedef struct packed {
      logic        stall;
      logic        rv;
      logic [31:0] tgt;
      logic        trap;
      logic        tret;
      logic        halt;
      logic        resume;
      logic [31:0] e_pc;
      logic        e_valid;
      logic [31:0] e_epc;
      logic        e_mis;
      logic [1:0]  e_st;
   } row_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pp;
      logic        valid;
      logic [31:0] epc;
      logic        mis;
      logic [1:0]  st;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errs = 0;
   obs_t sb_q[$];

   always #5 clk = ~clk;

   pc_sequencer_if #(.XLEN(32)) bus ();

   pc_sequencer #(
      .XLEN         (32),
      .INSTR_BYTES  (4),
      .RESET_VECTOR (32'h0000_0000),
      .TRAP_VECTOR  (32'h0000_0100)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic row_t mk(input logic s, input logic rv, input logic [31:0] tgt,
                               input logic tr, input logic rt, input logic h, input logic r,
                               input logic [31:0] pc, input logic v, input logic [31:0] epc,
                               input logic m, input logic [1:0] st);
      row_t x;
      x = '{s, rv, tgt, tr, rt, h, r, pc, v, epc, m, st};
      return x;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o = '{bus.pc_o, bus.pc_plus_o, bus.pc_valid_o, bus.epc_o, bus.misalign_o, bus.state_o};
      return o;
   endfunction

   // Drive one cycle of stimulus and queue the outputs expected during that cycle.
   task automatic drive_row(input row_t r);
      obs_t e;
      bus.stall_i           = r.stall;
      bus.redirect_valid_i  = r.rv;
      bus.redirect_target_i = r.tgt;
      bus.trap_i            = r.trap;
      bus.trap_return_i     = r.tret;
      bus.halt_i            = r.halt;
      bus.resume_i          = r.resume;
      e = '{r.e_pc, r.e_pc + 32'd4, r.e_valid, r.e_epc, r.e_mis, r.e_st};
      sb_q.push_back(e);
   endtask

   task automatic test_reset();
      row_t rows[5];
      obs_t exp_o, got_o;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_row(mk(L0, L0, 32'h0, L0, L0, L0, L0, 32'h0, L0, 32'h0, L0, 2'd0));
         @(negedge clk);
         exp_o = sb_q.pop_front();
         got_o = sample();
         n_checks++;
         if (got_o !== exp_o) begin
            n_errs++;
            $display("FAIL reset_hold[%0d]: got %h want %h (pc,pp,valid,epc,mis,st)", i, got_o, exp_o);
         end
         @(posedge clk);
      end
      #1 rst_n = 1'b1;
      rows[0] = mk(L1, L1, 32'h500, L1, L0, L0, L0, 32'h0, L0, 32'h0, L0, 2'd0);
      rows[1] = mk(L0, L0, 32'h0,   L0, L0, L0, L0, 32'h0, L1, 32'h0, L0, 2'd1);
      rows[2] = mk(L0, L0, 32'h0,   L0, L0, L0, L0, 32'h4, L1, 32'h0, L0, 2'd1);
      rows[3] = mk(L0, L0, 32'h0,   L0, L0, L0, L0, 32'h8, L1, 32'h0, L0, 2'd1);
      rows[4] = mk(L0, L0, 32'h0,   L0, L0, L0, L0, 32'hC, L1, 32'h0, L0, 2'd1);
      for (int i = 0; i < 5; i++) begin
         drive_row(rows[i]);
         @(negedge clk);
         exp_o = sb_q.pop_front();
         got_o = sample();
         n_checks++;
         if (got_o !== exp_o) begin
            n_errs++;
            $display("FAIL boot_seq[%0d]: got %h want %h (pc,pp,valid,epc,mis,st)", i, got_o, exp_o);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_stall_redirect();
      row_t rows[5];
      obs_t exp_o, got_o;
      rows[0] = mk(L1, L0, 32'h0,        L0, L0, L0, L0, 32'h10,       L0, 32'h0, L0, 2'd1);
      rows[1] = mk(L1, L0, 32'h0,        L0, L0, L0, L0, 32'h10,       L0, 32'h0, L0, 2'd1);
      rows[2] = mk(L1, L0, 32'h0,        L0, L0, L0, L0, 32'h10,       L0, 32'h0, L0, 2'd1);
      rows[3] = mk(L1, L1, 32'h12345678, L0, L0, L0, L0, 32'h10,       L0, 32'h0, L0, 2'd1);
      rows[4] = mk(L0, L1, 32'h40,       L0, L0, L0, L0, 32'h12345678, L1, 32'h0, L0, 2'd1);
      for (int i = 0; i < 5; i++) begin
         drive_row(rows[i]);
         @(negedge clk);
         exp_o = sb_q.pop_front();
         got_o = sample();
         n_checks++;
         if (got_o !== exp_o) begin
            n_errs++;
            $display("FAIL stall_redirect[%0d]: got %h want %h (pc,pp,valid,epc,mis,st)", i, got_o, exp_o);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_misalign();
      row_t rows[3];
      obs_t exp_o, got_o;
      rows[0] = mk(L0, L1, 32'hAABBCCDD, L0, L0, L0, L0, 32'h40,  L1, 32'h0,  L0, 2'd1);
      rows[1] = mk(L0, L0, 32'h0,        L0, L0, L0, L0, 32'h100, L1, 32'h40, L1, 2'd1);
      rows[2] = mk(L0, L1, 32'h200,      L0, L0, L0, L0, 32'h104, L1, 32'h40, L0, 2'd1);
      for (int i = 0; i < 3; i++) begin
         drive_row(rows[i]);
         @(negedge clk);
         exp_o = sb_q.pop_front();
         got_o = sample();
         n_checks++;
         if (got_o !== exp_o) begin
            n_errs++;
            $display("FAIL misalign[%0d]: got %h want %h (pc,pp,valid,epc,mis,st)", i, got_o, exp_o);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_trap_return();
      row_t rows[5];
      obs_t exp_o, got_o;
      rows[0] = mk(L0, L1, 32'h12345678, L1, L0, L0, L0, 32'h200, L1, 32'h40,  L0, 2'd1);
      rows[1] = mk(L0, L0, 32'h0,        L0, L0, L0, L0, 32'h100, L1, 32'h200, L0, 2'd1);
      rows[2] = mk(L0, L0, 32'h0,        L0, L1, L0, L0, 32'h104, L1, 32'h200, L0, 2'd1);
      rows[3] = mk(L0, L0, 32'h0,        L0, L0, L0, L0, 32'h200, L1, 32'h200, L0, 2'd1);
      rows[4] = mk(L0, L1, 32'h80,       L0, L0, L0, L0, 32'h204, L1, 32'h200, L0, 2'd1);
      for (int i = 0; i < 5; i++) begin
         drive_row(rows[i]);
         @(negedge clk);
         exp_o = sb_q.pop_front();
         got_o = sample();
         n_checks++;
         if (got_o !== exp_o) begin
            n_errs++;
            $display("FAIL trap_return[%0d]: got %h want %h (pc,pp,valid,epc,mis,st)", i, got_o, exp_o);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_halt_resume();
      row_t rows[8];
      obs_t exp_o, got_o;
      rows[0] = mk(L0, L0, 32'h0,        L0, L0, L1, L0, 32'h80,  L1, 32'h200, L0, 2'd1);
      rows[1] = mk(L0, L1, 32'h300,      L0, L0, L0, L0, 32'h80,  L0, 32'h200, L0, 2'd2);
      rows[2] = mk(L1, L0, 32'h0,        L0, L1, L1, L0, 32'h80,  L0, 32'h200, L0, 2'd2);
      rows[3] = mk(L0, L0, 32'h0,        L0, L0, L0, L1, 32'h80,  L0, 32'h200, L0, 2'd2);
      rows[4] = mk(L0, L0, 32'h0,        L0, L0, L0, L0, 32'h80,  L1, 32'h200, L0, 2'd1);
      rows[5] = mk(L0, L0, 32'h0,        L0, L0, L1, L0, 32'h84,  L1, 32'h200, L0, 2'd1);
      rows[6] = mk(L0, L0, 32'h0,        L1, L0, L0, L0, 32'h84,  L0, 32'h200, L0, 2'd2);
      rows[7] = mk(L0, L1, 32'hFFFFFFFC, L0, L0, L0, L0, 32'h100, L1, 32'h84,  L0, 2'd1);
      for (int i = 0; i < 8; i++) begin
         drive_row(rows[i]);
         @(negedge clk);
         exp_o = sb_q.pop_front();
         got_o = sample();
         n_checks++;
         if (got_o !== exp_o) begin
            n_errs++;
            $display("FAIL halt_resume[%0d]: got %h want %h (pc,pp,valid,epc,mis,st)", i, got_o, exp_o);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_wrap();
      row_t rows[3];
      obs_t exp_o, got_o;
      rows[0] = mk(L0, L0, 32'h0, L0, L0, L0, L0, 32'hFFFFFFFC, L1, 32'h84, L0, 2'd1);
      rows[1] = mk(L0, L0, 32'h0, L0, L0, L0, L0, 32'h00000000, L1, 32'h84, L0, 2'd1);
      rows[2] = mk(L0, L0, 32'h0, L0, L0, L0, L0, 32'h00000004, L1, 32'h84, L0, 2'd1);
      for (int i = 0; i < 3; i++) begin
         drive_row(rows[i]);
         @(negedge clk);
         exp_o = sb_q.pop_front();
         got_o = sample();
         n_checks++;
         if (got_o !== exp_o) begin
            n_errs++;
            $display("FAIL wrap[%0d]: got %h want %h (pc,pp,valid,epc,mis,st)", i, got_o, exp_o);
         end
         @(posedge clk);
         #1;
      end
   endtask

   // Reset asserted between edges must clear state without waiting for a clock.
   task automatic test_async_reset();
      obs_t exp_o, got_o;
      drive_row(mk(L0, L0, 32'h0, L0, L0, L0, L0, 32'h0, L0, 32'h0, L0, 2'd0));
      #2 rst_n = 1'b0;
      #1;
      exp_o = sb_q.pop_front();
      got_o = sample();
      n_checks++;
      if (got_o !== exp_o) begin
         n_errs++;
         $display("FAIL async_reset: got %h want %h (pc,pp,valid,epc,mis,st)", got_o, exp_o);
      end
   endtask

   initial begin
      bus.stall_i           = 1'b0;
      bus.redirect_valid_i  = 1'b0;
      bus.redirect_target_i = '0;
      bus.trap_i            = 1'b0;
      bus.trap_return_i     = 1'b0;
      bus.halt_i            = 1'b0;
      bus.resume_i          = 1'b0;
      #1;
      test_reset();
      test_stall_redirect();
      test_misalign();
      test_trap_return();
      test_halt_resume();
      test_wrap();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the MonoCycle CPU, replacing the bare clocked PC register. It holds the fetch address and applies, in a fixed priority: sequential increment, stall, branch/jump redirect, trap entry, trap return and halt/resume. It sits between the next-address logic and instruction memory, and raises a fault on misaligned redirect targets.

Parameters:
XLEN, 32, address width in bits
INSTR_BYTES, 4, sequential step in bytes; power of two, ≥1
RESET_VECTOR, 32'h0000_0000, PC value after reset (XLEN bits, aligned)
TRAP_VECTOR, 32'h0000_0100, PC value on trap entry (XLEN bits, aligned)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hold PC this cycle
redirect_valid_i  in  1  take redirect_target_i
redirect_target_i  in  XLEN  branch/jump target
trap_i  in  1  external trap request
trap_return_i  in  1  return to epc_o
halt_i  in  1  enter HALT
resume_i  in  1  leave HALT
pc_o  out  XLEN  current fetch address
pc_valid_o  out  1  pc_o is a live fetch this cycle
pc_plus_o  out  XLEN  pc_o + INSTR_BYTES, combinational, modulo 2^XLEN
epc_o  out  XLEN  saved PC from the last trap or misalignment fault
misalign_o  out  1  one-cycle pulse: redirect target was misaligned
state_o  out  2  FSM state (BOOT=0, RUN=1, HALT=2)

Behaviour:
- Reset: the asynchronous assert of rst_n=0 forces the following values:
  - pc_o=RESET_VECTOR
  - epc_o=0
  - misalign_o=0
  - state=BOOT
  - pc_valid_o=0
- Reset asserted mid-operation overrides everything immediately.
- All other updates happen on the rising clock edge.
- FSM:
  - BOOT: lasts exactly one cycle after rst_n deasserts. pc_o holds RESET_VECTOR. All inputs are ignored. Next state is RUN.
  - RUN: pc_valid_o=1 unless stall_i=1. Per-edge priority, highest first:
    1. trap_i: epc_o <= pc_o; pc_o <= TRAP_VECTOR.
    2. trap_return_i: pc_o <= epc_o.
    3. redirect_valid_i with aligned target: pc_o <= target.
    4. redirect_valid_i with misaligned target (target mod INSTR_BYTES ≠ 0): epc_o <= pc_o; pc_o <= TRAP_VECTOR; misalign_o=1 for the next cycle only.
    5. halt_i: pc_o holds; state <= HALT.
    6. stall_i: pc_o holds.
    7. Otherwise: pc_o <= pc_plus_o.
  - Redirect, trap and trap return take effect even while stall_i=1, because flush beats stall. Halt requested during a stall is also taken.
  - HALT: pc_valid_o=0 and pc_o holds.
    - resume_i => RUN next edge, pc_o unchanged. The first valid fetch is the held address.
    - trap_i in HALT => trap entry as above and state <= RUN.
    - Redirect, trap_return, halt and stall are ignored in HALT.
- Wrap-around: increment is modulo 2^XLEN. pc_o = {XLEN{1}} - INSTR_BYTES + 1 steps to 0 with no flag.
- Nested traps: epc_o is simply overwritten; there is no stack.
- Latency: every control input is seen on pc_o one edge later; nothing is registered on the input side.
- pc_plus_o is combinational from pc_o.

Decomposition:
- Package pc_seq_pkg holds:
  - the state typedef enum logic [1:0] {PCS_BOOT, PCS_RUN, PCS_HALT}
  - the localparam for the alignment mask width, $clog2(INSTR_BYTES)
- One sub-module, pc_next_sel: the combinational priority mux that produces next_pc, the epc write enable and the misalign flag. The top level keeps the FSM and the registers.

Test Plan:
- Reset and boot: rst_n low for 3 cycles, then high.
  - During reset and on the first edge after release: pc_o=0, pc_valid_o=0.
  - On the next edges: pc_o = 0 then 4, 8, 12; pc_valid_o=1.
- Stall versus redirect, with pc_o=0x10:
  - stall_i=1 for 2 cycles: pc_o stays 0x10.
  - Same, but redirect_valid_i=1 with target 0x12345678 on the second stall cycle: pc_o=0x12345678 on the next edge.
- Misaligned redirect, with pc_o=0x40, target 0xAABBCCDD: next edge gives pc_o=0x100, epc_o=0x40, misalign_o high for exactly one cycle.
- Trap and return, with pc_o=0x200:
  - trap_i and redirect_valid_i both asserted: pc_o=0x100 (trap wins), epc_o=0x200.
  - Later, trap_return_i: pc_o=0x200, then 0x204.
- Halt/resume, with pc_o=0x80:
  - halt_i: pc_o holds 0x80, pc_valid_o=0, state_o=2. Redirect while halted is ignored.
  - resume_i: state_o=1, pc_o=0x80, then 0x84.
- Wrap-around: redirect to 0xFFFFFFFC gives pc_o sequence 0xFFFFFFFC, 0x00000000, 0x00000004. Asynchronous reset asserted mid-cycle forces pc_o=0 before the next edge.
